// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd1;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc1;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: load a new entry, insert a bubble (PC kept), or hold.
module if_id_pipe_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NopWord = DEFAULT_NOP_WORD
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q.instr <= NopWord;
      q_q.pc1   <= '0;
      q_q.valid <= 1'b0;
    end else if (load_i) begin
      q_q <= d_i;
    end else if (bubble_i) begin
      q_q.instr <= NopWord;
      q_q.valid <= 1'b0;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack fetch FSM and IF/ID register.
// Define IF_PERF_COUNTERS_EN to add fetch/bubble performance counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCSource,
  input  logic [31:0] ID_PC,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instructions,
  output logic [31:0] IF_ID_PC,
  output logic        if_id_valid
`ifdef IF_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  hold_pc1_q, hold_pc1_d;
  logic [31:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]  pc_inc;
  logic         redirect;
  logic         load, bubble, fetch_done;
  if_id_t       pipe_d, pipe_q;

  assign redirect = PCSource & ~stall;
  assign pc_inc   = pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc1_d    = hold_pc1_q;
    redirect_pc_d = redirect_pc_q;
    load          = 1'b0;
    bubble        = 1'b0;
    fetch_done    = 1'b0;
    pipe_d        = '{instr: imem_data, pc1: pc_inc, valid: 1'b1};
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          bubble = 1'b1;
          if (imem_ack) begin
            pc_d = ID_PC;
          end else begin
            redirect_pc_d = ID_PC;
            state_d       = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (!stall) begin
            load       = 1'b1;
            fetch_done = 1'b1;
          end else begin
            hold_instr_d = imem_data;
            hold_pc1_d   = pc_inc;
            state_d      = HOLD;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        pipe_d = '{instr: hold_instr_q, pc1: hold_pc1_q, valid: 1'b1};
        if (redirect) begin
          pc_d    = ID_PC;
          bubble  = 1'b1;
          state_d = FETCH;
        end else if (!stall) begin
          // Buffered fetch is counted when it finally reaches IF/ID.
          load       = 1'b1;
          fetch_done = 1'b1;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        bubble = ~stall;
        if (imem_ack) begin
          pc_d    = redirect ? ID_PC : redirect_pc_q;
          state_d = FETCH;
        end else if (redirect) begin
          redirect_pc_d = ID_PC;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_instr_q  <= '0;
      hold_pc1_q    <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc1_q    <= hold_pc1_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Gated by Reset so no request is presented while the stage is held in reset.
  assign imem_req  = Reset & ((state_q == FETCH) | (state_q == DRAIN));
  assign imem_addr = pc_q;

  if_id_pipe_reg #(
    .NopWord(NOP_WORD)
  ) u_if_id_pipe_reg (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .load_i  (load),
    .bubble_i(bubble),
    .d_i     (pipe_d),
    .q_o     (pipe_q)
  );

  assign instructions = pipe_q.instr;
  assign IF_ID_PC     = pipe_q.pc1;
  assign if_id_valid  = pipe_q.valid;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (!stall) begin
      if (fetch_done) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bubble)     bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
